// File: rtl/enc_pkg.sv
// Shared types and helpers for the pending 8-to-3 encoder.
// Index width, FSM states and the one-hot helper used by the clear mask.
package enc_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } enc_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational picker: lowest set bit, or first set bit at/after start
// (wrapping) when round-robin is enabled.
module rr_prio_pick
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] start,
    input  logic             rr_en,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = rr_en ? start + IDX_W'(i) : IDX_W'(i);
            if (!any && mask[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_encoder8to3.sv
// Sequential 8-to-3 encoder: requests collect into a pending register and
// are granted one index at a time over a valid/ready output.
module pending_encoder8to3 #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3,
    parameter int RR    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flush,
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pending,
    output logic             overflow
);

    import enc_pkg::*;

    enc_state_t       state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             hs;
    logic [N_REQ-1:0] clr_mask;
    logic [N_REQ-1:0] post_mask;
    logic [IDX_W-1:0] start_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    assign hs        = (state_q == PRESENT) && out_ready;
    assign clr_mask  = hs ? onehot(out_idx_q) : '0;
    assign post_mask = pending_q & ~clr_mask;
    // The next pick already searches from the slot after the index leaving now
    assign start_ptr = hs ? out_idx_q + IDX_W'(1) : ptr_q;

    rr_prio_pick u_pick (
        .mask  (post_mask),
        .start (start_ptr),
        .rr_en (RR != 0),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        out_idx_d  = out_idx_q;
        pending_d  = post_mask | req;
        overflow_d = overflow_q | (|(req & post_mask));
        ptr_d      = start_ptr;

        unique case (state_q)
            IDLE: begin
                if (enable && pick_any) begin
                    out_idx_d = pick_idx;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                if (hs) begin
                    if (enable && pick_any) begin
                        out_idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d    = IDLE;
            out_idx_d  = '0;
            pending_d  = '0;
            overflow_d = 1'b0;
            ptr_d      = ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_idx_q  <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_idx_q  <= out_idx_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = (state_q == PRESENT);
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pending_encoder8to3.sv
// Bench for pending_encoder8to3: fixed-priority and round-robin instances
// share stimulus and are checked against a per-edge behavioural model.
module tb_pending_encoder8to3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b1;

    logic [2:0] idx0, idx1;
    logic       valid0, valid1;
    logic [7:0] pend0, pend1;
    logic       ovf0, ovf1;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    pending_encoder8to3 #(.N_REQ(8), .IDX_W(3), .RR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .req(req), .out_idx(idx0), .out_valid(valid0),
        .out_ready(out_ready), .pending(pend0), .overflow(ovf0)
    );

    pending_encoder8to3 #(.N_REQ(8), .IDX_W(3), .RR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .req(req), .out_idx(idx1), .out_valid(valid1),
        .out_ready(out_ready), .pending(pend1), .overflow(ovf1)
    );

    // Model state, [0] fixed priority, [1] round-robin
    logic [7:0] m_pend [2];
    bit         m_valid [2];
    int         m_idx [2];
    int         m_ptr [2];
    bit         m_ovf [2];

    function automatic int pick(input logic [7:0] p, input int start, input bit rr);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = rr ? (start + k) % 8 : k;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_pend[m] = 8'h00; m_valid[m] = 0; m_idx[m] = 0;
                m_ptr[m] = 0; m_ovf[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                bit         hs;
                logic [7:0] clr, post;
                int         nptr, p;
                hs   = m_valid[m] && out_ready;
                clr  = hs ? (8'h01 << m_idx[m]) : 8'h00;
                post = m_pend[m] & ~clr;
                if (flush) begin
                    m_pend[m] = 8'h00; m_valid[m] = 0; m_ovf[m] = 0; m_idx[m] = 0;
                end else begin
                    if ((req & post) != 8'h00) m_ovf[m] = 1;
                    nptr = hs ? (m_idx[m] + 1) % 8 : m_ptr[m];
                    if (!m_valid[m] || hs) begin
                        p = enable ? pick(post, nptr, m == 1) : -1;
                        if (p >= 0) begin
                            m_valid[m] = 1; m_idx[m] = p;
                        end else begin
                            m_valid[m] = 0;
                        end
                    end
                    m_ptr[m]  = nptr;
                    m_pend[m] = post | req;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("fp_valid", int'(valid0), int'(m_valid[0]));
            chk("fp_pending", int'(pend0), int'(m_pend[0]));
            chk("fp_overflow", int'(ovf0), int'(m_ovf[0]));
            if (m_valid[0]) chk("fp_idx", int'(idx0), m_idx[0]);
            chk("rr_valid", int'(valid1), int'(m_valid[1]));
            chk("rr_pending", int'(pend1), int'(m_pend[1]));
            chk("rr_overflow", int'(ovf1), int'(m_ovf[1]));
            if (m_valid[1]) chk("rr_idx", int'(idx1), m_idx[1]);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        req = 8'hFF;
        #1 chk_on = 1'b1;
        step(2);
        chk("rst_valid", int'(valid0), 0);
        chk("rst_idx", int'(idx0), 0);
        chk("rst_pending", int'(pend1), 0);
        chk("rst_overflow", int'(ovf1), 0);
        rst_n = 1'b1; req = 8'h00;
        step(2);
        chk("idle_valid", int'(valid0), 0);
        chk("idle_pending", int'(pend0), 0);

        // Fixed priority drain of 2, 5, 7
        req = 8'hA4; step();
        req = 8'h00; step();
        chk("fp_first", int'(idx0), 2);
        step();
        chk("fp_second", int'(idx0), 5);
        step();
        chk("fp_third", int'(idx0), 7);
        chk("fp_third_v", int'(valid0), 1);
        step();
        chk("fp_done_v", int'(valid0), 0);
        chk("fp_done_p", int'(pend0), 0);

        // Backpressure holds index 3
        out_ready = 1'b0; req = 8'h08; step();
        req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_idx", int'(idx0), 3);
            chk("bp_hold_v", int'(valid0), 1);
        end
        out_ready = 1'b1; step();
        chk("bp_release", int'(valid0), 0);

        // Round-robin alternation with 0 and 7 held high
        req = 8'h81; step(2);
        chk("rr_ovf_set", int'(ovf1), 1);
        chk("rr_first", int'(idx1), 7);
        step();
        chk("rr_second", int'(idx1), 0);
        step();
        chk("rr_third", int'(idx1), 7);
        chk("fp_stuck", int'(idx0), 0);
        step(4);
        req = 8'h00; step(4);
        flush = 1'b1; step();
        flush = 1'b0;
        chk("flush_ovf", int'(ovf0), 0);

        // Re-request of the bit being cleared
        out_ready = 1'b0; req = 8'h10; step();
        req = 8'h00; step();
        chk("col_pre", int'(idx0), 4);
        req = 8'h10; out_ready = 1'b1; step();
        req = 8'h00;
        chk("col_pend", int'(pend0), 8'h10);
        chk("col_ovf", int'(ovf0), 0);
        step();
        chk("col_regrant", int'(idx0), 4);
        chk("col_regrant_v", int'(valid0), 1);
        step();

        // Enable gating and flush mid-grant
        enable = 1'b0; req = 8'h30; step();
        req = 8'h00; step();
        chk("en_pend", int'(pend0), 8'h30);
        chk("en_novalid", int'(valid0), 0);
        enable = 1'b1; out_ready = 1'b0; step();
        chk("en_grant", int'(idx0), 4);
        enable = 1'b0; step();
        chk("en_keep_v", int'(valid0), 1);
        out_ready = 1'b1; step();
        chk("en_done_v", int'(valid0), 0);
        chk("en_done_p", int'(pend0), 8'h20);
        enable = 1'b1; out_ready = 1'b0; step();
        chk("en_grant5", int'(idx0), 5);
        flush = 1'b1; req = 8'hFF; out_ready = 1'b1; step();
        flush = 1'b0; req = 8'h00;
        chk("flush_v", int'(valid0), 0);
        chk("flush_p", int'(pend0), 0);
        step();

        // Asynchronous reset during a grant
        out_ready = 1'b0; req = 8'h01; step();
        req = 8'h00; step();
        chk("ar_pre", int'(valid1), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(valid0), 0);
        chk("ar_pend", int'(pend1), 0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step(2);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
